// File: rtl/rct_wb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state and round-robin pointer.
package rct_wb_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index of the master that wins the next tie (0 after reset).
  typedef logic rr_ptr_t;

  localparam int NUM_M = 2;
endpackage

// File: rtl/rct_wb_arb2.sv
// Two-master Wishbone round-robin arbiter with locked bursts.
// Optional stall watchdog enabled by defining RCT_WB_ARB_TIMEOUT_EN.
module rct_wb_arb2
  import rct_wb_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int BUS_MASK       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_M-1:0]       m_cyc_i,
  input  logic [NUM_M-1:0]       m_stb_i,
  input  logic [NUM_M-1:0]       m_we_i,
  input  logic [2*BUS_WIDTH-1:0] m_adr_i,
  input  logic [2*BUS_WIDTH-1:0] m_dat_i,
  input  logic [2*BUS_MASK-1:0]  m_sel_i,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic [NUM_M-1:0]       m_err_o,
  output logic [BUS_WIDTH-1:0]   m_dat_o,
  output logic [NUM_M-1:0]       gnt_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [BUS_WIDTH-1:0]   wb_adr_o,
  output logic [BUS_WIDTH-1:0]   wb_dat_o,
  output logic [BUS_MASK-1:0]    wb_sel_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic [BUS_WIDTH-1:0]   wb_dat_i
);

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  rr_ptr_t          ptr_q, ptr_d;
  logic             pick;
  logic             busy;
  logic             own;
  logic             timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    pick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          // Tie goes to the pointer; a lone requester wins outright.
          pick    = (&m_cyc_i) ? ptr_q : m_cyc_i[1];
          state_d = BUSY;
          gnt_d   = pick ? 2'b10 : 2'b01;
          ptr_d   = ~pick;
        end
      end
      BUSY: begin
        if (!(|(m_cyc_i & gnt_q))) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign busy  = (state_q == BUSY);
  assign own   = gnt_q[1];
  assign gnt_o = gnt_q;

`ifdef RCT_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  assign timeout = busy && (wd_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      wd_cnt <= '0;
    else if (!busy || timeout)      wd_cnt <= '0;
    else if (wb_ack_i || wb_err_i)  wd_cnt <= '0;
    else if (wb_stb_o)              wd_cnt <= wd_cnt + CW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Slave side mirrors the owner only; everything reads 0 while idle.
  assign wb_cyc_o = busy & m_cyc_i[own];
  assign wb_stb_o = busy & m_stb_i[own] & ~timeout;
  assign wb_we_o  = busy & m_we_i[own];
  assign wb_adr_o = !busy ? '0 : own ? m_adr_i[2*BUS_WIDTH-1:BUS_WIDTH] : m_adr_i[BUS_WIDTH-1:0];
  assign wb_dat_o = !busy ? '0 : own ? m_dat_i[2*BUS_WIDTH-1:BUS_WIDTH] : m_dat_i[BUS_WIDTH-1:0];
  assign wb_sel_o = !busy ? '0 : own ? m_sel_i[2*BUS_MASK-1:BUS_MASK]   : m_sel_i[BUS_MASK-1:0];

  assign m_ack_o  = {busy & own & wb_ack_i, busy & ~own & wb_ack_i};
  assign m_err_o  = {busy & own & (wb_err_i | timeout), busy & ~own & (wb_err_i | timeout)};
  assign m_dat_o  = wb_dat_i;

endmodule

// File: doc/rct_wb_arb2.md
RCT_WB_ARB2 -- requirements
Module: rct_wb_arb2

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, address/data width.
REQ-002 SHALL have parameter BUS_MASK, default 4, byte-select width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, stall limit for the timeout watchdog.
REQ-004 SHALL have port clk_i  input  1  single clock for all logic.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port m_cyc_i  input  2  per-master cycle request, bit n = master n.
REQ-007 SHALL have port m_stb_i  input  2  per-master strobe.
REQ-008 SHALL have port m_we_i  input  2  per-master write enable.
REQ-009 SHALL have port m_adr_i  input  2*BUS_WIDTH  master n at [n*BUS_WIDTH +: BUS_WIDTH].
REQ-010 SHALL have port m_dat_i  input  2*BUS_WIDTH  write data, same packing.
REQ-011 SHALL have port m_sel_i  input  2*BUS_MASK  byte selects, same packing.
REQ-012 SHALL have port m_ack_o  output  2  per-master acknowledge.
REQ-013 SHALL have port m_err_o  output  2  per-master error.
REQ-014 SHALL have port m_dat_o  output  BUS_WIDTH  read data broadcast to both masters.
REQ-015 SHALL have port gnt_o  output  2  one-hot current owner, 0 when idle.
REQ-016 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  slave-side controls.
REQ-017 SHALL have ports wb_adr_o, wb_dat_o  output  BUS_WIDTH each; wb_sel_o  output  BUS_MASK.
REQ-018 SHALL have ports wb_ack_i, wb_err_i  input  1 each; wb_dat_i  input  BUS_WIDTH.

Function
REQ-019 SHALL implement FSM states IDLE and BUSY; gnt_o is a register, nonzero only in BUSY.
REQ-020 In IDLE with any m_cyc_i set, SHALL enter BUSY next edge granting one master; single requester wins unconditionally.
REQ-021 Both requesting in IDLE: SHALL grant the master not served last (round-robin pointer); pointer updates on every grant.
REQ-022 Arbitration latency SHALL be exactly 1 cycle: wb_cyc_o rises the cycle after m_cyc_i rises from idle.
REQ-023 In BUSY, wb_cyc/stb/we/adr/dat/sel_o SHALL combinationally follow the owner's inputs; in IDLE all are 0.
REQ-024 wb_ack_i/wb_err_i SHALL route combinationally to the owner bit only; non-owner ack/err always 0; m_dat_o = wb_dat_i.
REQ-025 Ownership SHALL persist while owner m_cyc_i is high (locked bursts); the edge seeing it low returns to IDLE.
REQ-026 At least one IDLE cycle SHALL separate consecutive grants; a pending requester is granted from that IDLE cycle.
REQ-027 Non-owner request changes SHALL have no effect on slave-side outputs during BUSY.

Reset
REQ-028 rst_i high SHALL asynchronously force IDLE, gnt_o=0, pointer favouring master 0, watchdog counter 0; all wb_* outputs and m_ack_o/m_err_o read 0.
REQ-029 Reset mid-transfer SHALL drop wb_cyc_o immediately, with no ack/err delivered to the former owner.

Configuration
REQ-030 With RCT_WB_ARB_TIMEOUT_EN defined: counter increments each cycle wb_stb_o=1 without wb_ack_i/wb_err_i, clears on ack/err or IDLE; at TIMEOUT_CYCLES SHALL pulse owner m_err_o one cycle, force wb_stb_o=0 that cycle, clear counter.
REQ-031 Without RCT_WB_ARB_TIMEOUT_EN: no counter logic, no synthesized errors, stalls last indefinitely.

Structure
REQ-032 FSM state enum and the round-robin pointer type SHALL live in a shared rct_wb_pkg package.
REQ-033 SHALL be a single module; the watchdog is inline, no sub-module.

Verification
REQ-034 Only m_cyc_i=2'b01, slave acks in 2 cycles -> gnt_o=01 one cycle later, m_ack_o=01 once, IDLE after cyc drops.
REQ-035 Both request from reset -> master 0 granted; after release master 1 granted after one IDLE cycle.
REQ-036 Master 1 holds cyc across 4 acked beats while master 0 requests -> gnt_o stays 10 until release, then 01.
REQ-037 Macro defined, TIMEOUT_CYCLES=8, slave never acks -> owner m_err_o pulses after 8 stall cycles; undefined -> no err ever.
REQ-038 rst_i asserted mid-transfer with wb_cyc_o=1 -> wb_cyc_o=0 and gnt_o=0 same cycle, no m_ack_o pulse.
